// File: rtl/ws_column_seq_if.sv
// ws_column_seq_if: job control, weight-source, activation handshake and PE-column
// control signals of one weight-stationary column sequencer.
interface ws_column_seq_if #(
    parameter int OP_WIDTH   = 8,
    parameter int CTRL_WIDTH = 9,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_PE     = 4
);
    logic [ADDR_WIDTH:0]   cfg_num_weights;
    logic [15:0]           cfg_num_passes;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  w_valid;
    logic                  w_ready;
    logic [OP_WIDTH-1:0]   w_data;
    logic [NUM_PE-1:0]     wctrl;
    logic [OP_WIDTH-1:0]   weight;
    logic                  iact_valid;
    logic                  iact_ready;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  psum_valid;

    modport master (
        output cfg_num_weights, cfg_num_passes, start, w_valid, w_data, iact_valid,
        input  busy, done, w_ready, wctrl, weight, iact_ready, ctrl, psum_valid
    );

    modport slave (
        input  cfg_num_weights, cfg_num_passes, start, w_valid, w_data, iact_valid,
        output busy, done, w_ready, wctrl, weight, iact_ready, ctrl, psum_valid
    );
endinterface

// File: rtl/ws_column_seq.sv
// ws_column_seq: loads a weight set into each PE of a column, runs the programmed
// compute passes paced by the activation stream, drains the MAC pipe and signals done.
module ws_column_seq #(
    parameter int OP_WIDTH   = 8,
    parameter int CTRL_WIDTH = 9,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_PE     = 4,
    parameter int MAC_LAT    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ws_column_seq_if.slave bus
);
    localparam int PE_W = NUM_PE > 1 ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;

    state_t                state, next;
    logic [ADDR_WIDTH:0]   num_weights;
    logic [15:0]           num_passes;
    logic [15:0]           pass_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt;
    logic [ADDR_WIDTH-1:0] k_cnt;
    logic [PE_W-1:0]       pe_idx;
    logic [MAC_LAT-1:0]    pipe;
    logic                  w_beat, i_beat, w_last, k_last, pe_last, pass_last;

    assign w_beat    = bus.w_valid && state == LOAD;
    assign i_beat    = bus.iact_valid && state == COMPUTE;
    assign w_last    = {1'b0, w_cnt} == num_weights - (ADDR_WIDTH + 1)'(1);
    assign k_last    = {1'b0, k_cnt} == num_weights - (ADDR_WIDTH + 1)'(1);
    assign pe_last   = pe_idx == PE_W'(NUM_PE - 1);
    assign pass_last = pass_cnt == num_passes - 16'd1;

    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.w_ready    = state == LOAD;
    assign bus.iact_ready = state == COMPUTE;
    assign bus.ctrl       = CTRL_WIDTH'({i_beat && k_last, 6'b0, i_beat});
    assign bus.psum_valid = pipe[MAC_LAT-1];

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (bus.start) next = bus.cfg_num_weights == '0 ? DONE : LOAD;
            LOAD:    if (w_beat && w_last && pe_last) next = num_passes == '0 ? DONE : COMPUTE;
            COMPUTE: if (i_beat && k_last && pass_last) next = DRAIN;
            DRAIN:   if (pipe == '0) next = DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            num_weights <= '0;
            num_passes  <= '0;
            pass_cnt    <= '0;
            w_cnt       <= '0;
            k_cnt       <= '0;
            pe_idx      <= '0;
            pipe        <= '0;
            bus.wctrl   <= '0;
            bus.weight  <= {OP_WIDTH{1'b0}};
        end else begin
            state     <= next;
            pipe      <= MAC_LAT'({pipe, i_beat});
            bus.wctrl <= w_beat ? NUM_PE'(1) << pe_idx : '0;
            if (w_beat) bus.weight <= bus.w_data;
            if (state == IDLE && bus.start) begin
                num_weights <= bus.cfg_num_weights;
                num_passes  <= bus.cfg_num_passes;
                pass_cnt    <= '0;
                w_cnt       <= '0;
                k_cnt       <= '0;
                pe_idx      <= '0;
            end
            if (w_beat) begin
                w_cnt <= w_last ? '0 : w_cnt + ADDR_WIDTH'(1);
                if (w_last) pe_idx <= pe_last ? '0 : pe_idx + PE_W'(1);
            end
            // read_reset beat rewinds the PE read pointers and closes one pass
            if (i_beat) begin
                k_cnt <= k_last ? '0 : k_cnt + ADDR_WIDTH'(1);
                if (k_last) pass_cnt <= pass_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_ws_column_seq.sv
// tb_ws_column_seq: directed jobs checked every cycle against a beat-counting model,
// plus hand-computed cycle positions of wctrl, ctrl, psum_valid and done.
module tb_ws_column_seq;
    localparam int NUM_PE  = 4;
    localparam int MAC_LAT = 2;
    localparam int MAXC    = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int done_total = 0;

    bit         act      = 1'b0;
    int         nw       = 0;
    int         np       = 0;
    int         ld_beats = 0;
    int         cp_beats = 0;
    int         done_at  = -1;
    int         rst_cyc  = 0;
    logic [3:0] m_wctrl  = '0;
    logic [7:0] m_weight = '0;
    bit         c0_h [MAXC];
    // per cycle: [11:8] wctrl, [3] done, [2] psum_valid, [1] ctrl[7], [0] ctrl[0]
    logic [11:0] lg [MAXC];

    ws_column_seq_if bus ();

    ws_column_seq dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    // Inputs for the cycle are already driven; sample mid-cycle, compare, advance model.
    task automatic step();
        bit ld, cp, e_c0, e_c7, e_psum;
        @(negedge clk);
        lg[cyc] = {bus.wctrl, 4'b0, bus.done, bus.psum_valid, bus.ctrl[7], bus.ctrl[0]};
        if (bus.done) done_total++;
        if (!rst_n) begin
            act = 1'b0;
            m_wctrl = '0;
            m_weight = '0;
            rst_cyc = cyc;
            c0_h[cyc] = 1'b0;
            chk("reset_outputs", int'({bus.busy, bus.done, bus.w_ready, bus.iact_ready,
                bus.psum_valid, bus.wctrl, bus.ctrl, bus.weight}), 0);
        end else begin
            ld = act && ld_beats < NUM_PE * nw;
            cp = act && !ld && cp_beats < np * nw;
            e_c0 = cp && bus.iact_valid;
            e_c7 = e_c0 && ((cp_beats + 1) % nw == 0);
            e_psum = cyc - MAC_LAT > rst_cyc && c0_h[cyc - MAC_LAT];
            chk("busy", int'(bus.busy), int'(act));
            chk("done", int'(bus.done), int'(act && cyc == done_at));
            chk("w_ready", int'(bus.w_ready), int'(ld));
            chk("iact_ready", int'(bus.iact_ready), int'(cp));
            chk("ctrl", int'(bus.ctrl), int'({e_c7, 6'b0, e_c0}));
            chk("psum_valid", int'(bus.psum_valid), int'(e_psum));
            chk("wctrl", int'(bus.wctrl), int'(m_wctrl));
            chk("weight", int'(bus.weight), int'(m_weight));
            c0_h[cyc] = e_c0;
            m_wctrl = '0;
            if (ld && bus.w_valid) begin
                m_wctrl = 4'(1 << (ld_beats / nw));
                m_weight = bus.w_data;
                ld_beats++;
                if (ld_beats == NUM_PE * nw && np == 0) done_at = cyc + 1;
            end
            if (e_c0) begin
                cp_beats++;
                if (cp_beats == np * nw) done_at = cyc + MAC_LAT + 2;
            end
            if (act && cyc == done_at) act = 1'b0;
            else if (!act && bus.start) begin
                act = 1'b1;
                nw = int'(bus.cfg_num_weights);
                np = int'(bus.cfg_num_passes);
                ld_beats = 0;
                cp_beats = 0;
                done_at = nw == 0 ? cyc + 1 : -1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        bus.w_valid = 1'b0;
        bus.iact_valid = 1'b0;
        repeat (n) step();
    endtask

    // valid patterns repeat with period *per and are high for the first *on slots
    task automatic job(input int nw_, input int np_, input int won, input int wper,
                       input int ion, input int iper, input int hold, input int spur,
                       input int limit, output int s0, output int dc);
        int d0;
        d0 = done_total;
        s0 = cyc;
        dc = -1;
        for (int k = 0; k < limit && dc < 0; k++) begin
            bus.start = (k <= hold) || (k == spur);
            bus.cfg_num_weights = 11'(k == spur ? 5 : nw_);
            bus.cfg_num_passes = 16'(k == spur ? 4 : np_);
            bus.w_valid = (k % wper) < won;
            bus.iact_valid = (k % iper) < ion;
            bus.w_data = 8'(k * 37 + 11);
            step();
            if (done_total != d0) dc = cyc - 1 - s0;
        end
        bus.start = 1'b0;
        bus.w_valid = 1'b0;
        bus.iact_valid = 1'b0;
    endtask

    function automatic int cnt(input int b, input int a, input int e);
        int n = 0;
        for (int i = a; i < e; i++) n += b == 8 ? int'(|lg[i][11:8]) : int'(lg[i][b]);
        return n;
    endfunction

    initial begin
        int s0, dc;
        bus.start = 1'b0;
        bus.cfg_num_weights = '0;
        bus.cfg_num_passes = '0;
        bus.w_valid = 1'b0;
        bus.w_data = '0;
        bus.iact_valid = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step();
        rst_n = 1'b1;
        idle(2);

        job(3, 2, 1, 1, 1, 1, 0, -1, 100, s0, dc);
        chk("A_done_cycle", dc, 22);
        chk("A_wctrl_first", int'(lg[s0+2][11:8]), 1);
        chk("A_wctrl_pe0_last", int'(lg[s0+4][11:8]), 1);
        chk("A_wctrl_pe1_first", int'(lg[s0+5][11:8]), 2);
        chk("A_wctrl_pe3_last", int'(lg[s0+13][11:8]), 8);
        chk("A_wctrl_after_load", int'(lg[s0+14][11:8]), 0);
        chk("A_wctrl_beats", cnt(8, s0, s0 + dc), 12);
        chk("A_ctrl0_beats", cnt(0, s0, s0 + dc + 1), 6);
        chk("A_ctrl7_beat3", int'(lg[s0+15][1]), 1);
        chk("A_ctrl7_beat6", int'(lg[s0+18][1]), 1);
        chk("A_ctrl7_total", cnt(1, s0, s0 + dc + 1), 2);
        chk("A_psum_before", int'(lg[s0+14][2]), 0);
        chk("A_psum_first", int'(lg[s0+15][2]), 1);
        chk("A_psum_total", cnt(2, s0, s0 + dc + 1), 6);
        idle(2);
        chk("A_done_once", cnt(3, s0, cyc), 1);

        job(3, 2, 2, 3, 1, 2, 0, -1, 200, s0, dc);
        chk("B_done_cycle", dc, 34);
        chk("B_ctrl0_stall", int'(lg[s0+23][0]), 0);
        chk("B_ctrl7_beat3", int'(lg[s0+24][1]), 1);
        chk("B_ctrl0_beats", cnt(0, s0, s0 + dc + 1), 6);
        chk("B_ctrl7_total", cnt(1, s0, s0 + dc + 1), 2);
        idle(2);

        job(0, 3, 1, 1, 1, 1, 0, -1, 20, s0, dc);
        chk("C_nw0_done_cycle", dc, 1);
        idle(2);
        chk("C_nw0_no_wctrl", cnt(8, s0, cyc), 0);
        chk("C_nw0_no_ctrl", cnt(0, s0, cyc), 0);

        job(2, 0, 1, 1, 1, 1, 0, -1, 50, s0, dc);
        chk("D_np0_done_cycle", dc, 9);
        idle(2);
        chk("D_np0_wctrl_beats", cnt(8, s0, cyc), 8);
        chk("D_np0_no_ctrl", cnt(0, s0, cyc), 0);

        job(1, 1, 1, 1, 1, 1, 0, -1, 50, s0, dc);
        chk("E_min_done_cycle", dc, 9);
        idle(2);
        chk("E_min_psum", cnt(2, s0, cyc), 1);

        job(2, 1, 1, 1, 1, 1, 0, 3, 100, s0, dc);
        chk("F_ignored_start_done", dc, 14);
        idle(3);
        chk("F_ignored_start_once", cnt(3, s0, cyc), 1);
        chk("F_ignored_start_ctrl", cnt(0, s0, cyc), 2);

        job(1, 0, 1, 1, 1, 1, 6, -1, 50, s0, dc);
        chk("G_first_done", dc, 5);
        bus.start = 1'b1;
        bus.w_valid = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        idle(2);
        chk("G_second_done", int'(lg[s0+11][3]), 1);
        chk("G_two_dones", cnt(3, s0, cyc), 2);

        job(3, 4, 1, 1, 1, 1, 0, -1, 16, s0, dc);
        chk("H_no_early_done", dc, -1);
        bus.w_valid = 1'b1;
        bus.iact_valid = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        idle(6);
        chk("H_idle_after_reset", int'(bus.busy), 0);
        chk("H_psum_flushed", cnt(2, s0 + 16, cyc), 0);
        chk("H_no_done", cnt(3, s0, cyc), 0);

        job(1, 1, 1, 1, 1, 1, 0, -1, 50, s0, dc);
        chk("I_after_reset_done", dc, 9);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
